// File: rtl/onehot_codec_pipe.sv
// Registered one-hot decoder/encoder on valid/ready streams, with a per-word mode,
// invalid-code flagging, optional lowest-bit priority encoding and a saturating error counter.
module onehot_codec_pipe #(
    parameter int IDX_W = 2,
    parameter int PRIORITY = 0,
    parameter int ERRCNT_W = 8,
    localparam int ONEHOT_W = 2 ** IDX_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mode,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ONEHOT_W-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ONEHOT_W-1:0] out_data,
    output logic                out_err,
    input  logic                clr_err,
    output logic [ERRCNT_W-1:0] err_count
);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;
    localparam logic [ERRCNT_W-1:0] CNT_MAX = '1;

    // Handshake: a word transfers on any edge where valid && ready are both high;
    // the output stage may be refilled in the same cycle its current word drains.
    logic [0:0]          state;
    logic                accept;
    logic [ONEHOT_W-1:0] res_data;
    logic                res_err;
    logic [IDX_W-1:0]    low_idx;
    logic                none_set;
    logic                multi_set;

    assign out_valid = (state == FULL);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;

    // Scan from the top so the last assignment is the lowest set bit.
    always_comb begin
        low_idx = '0;
        for (int i = ONEHOT_W - 1; i >= 0; i--) begin
            if (in_data[i]) low_idx = IDX_W'(i);
        end
    end

    assign none_set  = (in_data == '0);
    assign multi_set = ((in_data & (in_data - ONEHOT_W'(1))) != '0);

    always_comb begin
        res_data = '0;
        res_err  = 1'b0;
        if (!mode) begin
            res_data = ONEHOT_W'(1) << in_data[IDX_W-1:0];
        end else if (none_set || (multi_set && PRIORITY == 0)) begin
            res_err = 1'b1;
        end else begin
            res_data = ONEHOT_W'(low_idx);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            out_data <= '0;
            out_err  <= 1'b0;
        end else if (accept) begin
            state    <= FULL;
            out_data <= res_data;
            out_err  <= res_err;
        end else if (out_ready) begin
            state <= EMPTY;
        end
    end

    // Counts errored accepts regardless of downstream backpressure; clear has priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
        end else if (clr_err) begin
            err_count <= '0;
        end else if (accept && res_err && err_count != CNT_MAX) begin
            err_count <= err_count + ERRCNT_W'(1);
        end
    end

endmodule

// File: tb/tb_onehot_codec_pipe.sv
// Bench for onehot_codec_pipe: a strict-encode instance with a 2-bit counter and a
// priority-encode instance with an 8-bit counter, driven by the same stream.
module tb_onehot_codec_pipe;

  localparam int OH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mode = 1'b0;
  logic in_valid = 1'b0;
  logic [OH-1:0] in_data = '0;
  logic out_ready = 1'b0;
  logic clr_err = 1'b0;

  logic in_ready0, out_valid0, out_err0;
  logic [OH-1:0] out_data0;
  logic [1:0] err_count0;
  logic in_ready1, out_valid1, out_err1;
  logic [OH-1:0] out_data1;
  logic [7:0] err_count1;

  int chk_cnt = 0;
  int pass_cnt = 0;
  int cnt0 = 0;
  int cnt1 = 0;
  logic mdl_valid = 1'b0;
  logic [OH:0] exp0_q[$];
  logic [OH:0] exp1_q[$];
  logic [OH:0] e0, e1;

  onehot_codec_pipe #(.IDX_W(2), .PRIORITY(0), .ERRCNT_W(2)) u_dut0 (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0), .out_err(out_err0), .clr_err(clr_err), .err_count(err_count0)
  );

  onehot_codec_pipe #(.IDX_W(2), .PRIORITY(1), .ERRCNT_W(8)) u_dut1 (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .out_err(out_err1), .clr_err(clr_err), .err_count(err_count1)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: {err, data} from the rules of the codec, no knowledge of the RTL.
  function automatic logic [OH:0] ref_result(input logic m, input logic [OH-1:0] d, input int prio);
    int n;
    n = $countones(d);
    if (!m) return {1'b0, OH'(2 ** (int'(d) % OH))};
    if (n == 0 || (n > 1 && prio == 0)) return {1'b1, OH'(0)};
    for (int k = 0; k < OH; k++) begin
      if (d[k]) return {1'b0, OH'(k)};
    end
    return '0;
  endfunction

  function automatic int sat_inc(input int c, input int max);
    return (c < max) ? c + 1 : c;
  endfunction

  // driver: called just after a rising edge, applies one cycle of inputs
  task automatic drive(input logic v, input logic m, input logic [OH-1:0] d,
                       input logic ordy, input logic clr);
    logic acc;
    logic [OH:0] r0, r1;
    in_valid = v; mode = m; in_data = d; out_ready = ordy; clr_err = clr;
    acc = v && (!mdl_valid || ordy);
    r0 = ref_result(m, d, 0);
    r1 = ref_result(m, d, 1);
    if (acc) begin
      exp0_q.push_back(r0);
      exp1_q.push_back(r1);
    end
    @(posedge clk); #1;
    mdl_valid = acc ? 1'b1 : (ordy ? 1'b0 : mdl_valid);
    if (clr) begin
      cnt0 = 0; cnt1 = 0;
    end else if (acc) begin
      if (r0[OH]) cnt0 = sat_inc(cnt0, 3);
      if (r1[OH]) cnt1 = sat_inc(cnt1, 255);
    end
  endtask

  // monitor / scoreboard: samples on the falling edge
  always @(negedge clk) begin
    check("in_ready0", 32'(in_ready0), 32'(!mdl_valid || out_ready));
    check("in_ready1", 32'(in_ready1), 32'(!mdl_valid || out_ready));
    check("out_valid0", 32'(out_valid0), 32'(mdl_valid));
    check("out_valid1", 32'(out_valid1), 32'(mdl_valid));
    check("err_count0", 32'(err_count0), 32'(cnt0));
    check("err_count1", 32'(err_count1), 32'(cnt1));
    if (out_valid0 && out_ready) begin
      if (exp0_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL result0: got %0h expected nothing", {out_err0, out_data0});
      end else begin
        e0 = exp0_q.pop_front();
        check("result0", 32'({out_err0, out_data0}), 32'(e0));
      end
    end else if (out_valid0 && exp0_q.size() != 0) begin
      check("hold0", 32'({out_err0, out_data0}), 32'(exp0_q[0]));
    end
    if (out_valid1 && out_ready) begin
      if (exp1_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL result1: got %0h expected nothing", {out_err1, out_data1});
      end else begin
        e1 = exp1_q.pop_front();
        check("result1", 32'({out_err1, out_data1}), 32'(e1));
      end
    end else if (out_valid1 && exp1_q.size() != 0) begin
      check("hold1", 32'({out_err1, out_data1}), 32'(exp1_q[0]));
    end
  end

  initial begin
    int sat_exp[5];
    logic v, m, ordy, clr;
    logic [OH-1:0] d;
    sat_exp = '{1, 2, 3, 3, 3};

    // reset state
    @(negedge clk);
    check("rst_data0", 32'(out_data0), 32'(0));
    check("rst_err0", 32'(out_err0), 32'(0));
    check("rst_data1", 32'(out_data1), 32'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // decode sweep, back to back
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, OH'(i), 1'b1, 1'b0);
    drive(1'b1, 1'b0, 4'b1110, 1'b1, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0);

    // encode: valid, zero, multi-hot, top bit
    drive(1'b1, 1'b1, 4'b0100, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 4'b0000, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 4'b0110, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 4'b1000, 1'b1, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
    check("enc_cnt0", 32'(err_count0), 32'(2));
    check("enc_cnt1", 32'(err_count1), 32'(1));

    // counter saturation, then clear beating an errored accept
    drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 4'b0000, 1'b1, 1'b0);
      check("sat_cnt0", 32'(err_count0), 32'(sat_exp[i]));
    end
    drive(1'b1, 1'b1, 4'b0000, 1'b1, 1'b1);
    check("clr_cnt0", 32'(err_count0), 32'(0));
    check("clr_cnt1", 32'(err_count1), 32'(0));
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0);

    // backpressure: A held for three cycles, B accepted as A drains
    drive(1'b1, 1'b0, 4'd2, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 4'd1, 1'b0, 1'b0);
      check("bp_hold_data0", 32'(out_data0), 32'(4'b0100));
      check("bp_in_ready0", 32'(in_ready0), 32'(0));
    end
    drive(1'b1, 1'b0, 4'd1, 1'b1, 1'b0);
    check("bp_b_data0", 32'(out_data0), 32'(4'b0010));
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      m = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: d = OH'(1) << $urandom_range(0, 3);
        1: d = '0;
        default: d = OH'($urandom_range(0, 15));
      endcase
      ordy = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 19) == 0);
      drive(v, m, d, ordy, clr);
    end

    // asynchronous reset while a result is held
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 4'b1000, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 4'b0000, 1'b1, 1'b0);
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check("pre_rst_valid0", 32'(out_valid0), 32'(1));
    check("pre_rst_err0", 32'(out_err0), 32'(1));
    rst = 1'b1;
    #1;
    check("arst_valid0", 32'(out_valid0), 32'(0));
    check("arst_data0", 32'(out_data0), 32'(0));
    check("arst_err0", 32'(out_err0), 32'(0));
    check("arst_cnt0", 32'(err_count0), 32'(0));
    check("arst_valid1", 32'(out_valid1), 32'(0));
    check("arst_cnt1", 32'(err_count1), 32'(0));
    exp0_q.delete();
    exp1_q.delete();
    mdl_valid = 1'b0; cnt0 = 0; cnt1 = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready0", 32'(in_ready0), 32'(1));
    drive(1'b1, 1'b0, 4'd3, 1'b1, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0);

    check("q0_drained", 32'(exp0_q.size()), 32'(0));
    check("q1_drained", 32'(exp1_q.size()), 32'(0));
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/onehot_codec_pipe.md
Name: onehot_codec_pipe

Overview:
- Parametrised, registered one-hot decoder/encoder with a per-transaction mode select. Decode converts a binary index to a one-hot word; encode converts a one-hot word back to a binary index.
- Sits between a producer and consumer using valid/ready streams.
- Adds an output pipeline register, backpressure, invalid-code detection, optional priority encoding and a saturating error counter.

Parameters:
- IDX_W, 2, binary index width; one-hot width ONEHOT_W = 2**IDX_W (derived localparam, not overridable).
- PRIORITY, 0, encode policy: 0 = strict (multi-hot is an error), 1 = lowest set bit wins.
- ERRCNT_W, 8, width of the error counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- mode  input  1  0 = decode, 1 = encode; sampled with in_data on accept.
- in_valid  input  1  input word valid.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  ONEHOT_W  decode: index in bits [IDX_W-1:0], upper bits ignored; encode: one-hot candidate.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_data  output  ONEHOT_W  decode: one-hot word; encode: index zero-extended to ONEHOT_W.
- out_err  output  1  result came from an invalid encode input.
- clr_err  input  1  synchronous clear of err_count.
- err_count  output  ERRCNT_W  saturating count of errored results.

Behaviour:
- Reset is asynchronous, active-high: one clock; reset is asynchronous and active-high.
  - While rst=1: out_valid=0, out_data=0, out_err=0, err_count=0.
  - Any held result is discarded.
  - in_ready=1 from the first cycle after reset deassertion.
- Output stage is a two-state register, EMPTY (out_valid=0) and FULL (out_valid=1).
- in_ready = !out_valid || out_ready (combinational). Pass-through of a full stage in the same cycle is allowed.
- Accept = in_valid && in_ready. On accept, the result registers at the next rising edge: latency 1 cycle, throughput 1 word/cycle.
- State transitions:
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY when out_ready && !in_valid.
  - FULL -> FULL with new data when out_ready && in_valid.
  - FULL holds out_data/out_err stable while out_ready=0.
- in_data and mode are don't-care when in_valid=0. No state change without accept.
- Decode (mode=0):
  - out_data = 1 << in_data[IDX_W-1:0]; out_err=0.
  - in_data[ONEHOT_W-1:IDX_W] is ignored.
- Encode (mode=1):
  - Exactly one bit set at position k: out_data = k, zero-extended; out_err=0.
  - in_data = 0: out_data=0, out_err=1, regardless of PRIORITY.
  - Two or more bits set, PRIORITY=0: out_data=0, out_err=1.
  - Two or more bits set, PRIORITY=1: out_data = index of lowest set bit; out_err=0.
- err_count:
  - Increments by 1 on each accept whose computed out_err=1. Update is in the same edge as the result register.
  - Saturates at 2**ERRCNT_W-1 and does not wrap.
  - clr_err=1 sets the counter to 0 at the next edge. Clear wins over a simultaneous errored accept (result 0, not 1).
  - Counter is independent of out_ready/backpressure.
- Mode may change on any accepted word; no idle cycle is required between modes.

Test Plan:
- Decode sweep: IDX_W=2, mode=0, in_data=0,1,2,3 back-to-back with out_ready=1 -> out_data 0001, 0010, 0100, 1000, one cycle after each accept; out_err=0; in_ready stays 1.
- Encode valid and invalid, PRIORITY=0: mode=1, in_data=0100 -> out_data=0010, err=0. in_data=0000 -> 0000, err=1. in_data=0110 -> 0000, err=1. err_count=2 afterwards.
- Priority encode, PRIORITY=1: in_data=0110 -> out_data=0001, err=0. in_data=1000 -> 0011. in_data=0000 -> err=1. err_count=1.
- Backpressure: accept word A, then hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_data=A stable, no further accept. Raise out_ready -> A consumed and B accepted in the same cycle; B appears the next cycle.
- Counter limits: ERRCNT_W=2, five errored encodes -> err_count 1,2,3,3,3. Then clr_err coincident with an errored accept -> err_count=0.
- Reset mid-operation: out_valid=1 with out_ready=0, assert rst asynchronously between edges -> out_valid, out_data, out_err and err_count go 0 immediately. in_ready=1 after release.
